// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared widths, FSM states and pulse-width helpers for the servo sequencer
package servo_pkg;

  localparam int PW_W    = 12;
  localparam int FRAME_W = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Limit a requested pulse width to the mechanically safe window
  function automatic logic [PW_W-1:0] clamp_pw(
    input logic [PW_W-1:0] pw,
    input logic [PW_W-1:0] lo,
    input logic [PW_W-1:0] hi
  );
    logic [PW_W-1:0] r;
    r = pw;
    if (pw < lo) r = lo;
    else if (pw > hi) r = hi;
    return r;
  endfunction

  // Move cur toward tgt by at most step; the difference is taken one bit wider and signed
  // so a small cur never wraps when stepping down
  function automatic logic [PW_W-1:0] step_toward(
    input logic [PW_W-1:0] cur,
    input logic [PW_W-1:0] tgt,
    input logic [PW_W-1:0] step
  );
    logic signed [PW_W:0] diff;
    logic signed [PW_W:0] s;
    logic [PW_W-1:0]      r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    s    = $signed({1'b0, step});
    if (diff > s) r = cur + step;
    else if (diff < -s) r = cur - step;
    else r = tgt;
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - microsecond prescaler and servo frame counter
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int FRAME_US = 20000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_us_tick,
  output logic               o_frame_end
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRESC_W-1:0] r_presc;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic               w_us_tick;
  logic               w_frame_last;

  assign w_us_tick    = (r_presc == PRESC_W'(TICK_DIV - 1));
  assign w_frame_last = (r_frame_cnt == FRAME_W'(FRAME_US - 1));

  assign o_frame_cnt = r_frame_cnt;
  assign o_us_tick   = w_us_tick;
  assign o_frame_end = w_us_tick & w_frame_last;

  // Prescale sysclk to 1 us ticks and count ticks across one servo frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_presc     <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_us_tick) r_presc <= '0;
      else r_presc <= r_presc + 1'b1;
      if (w_us_tick) begin
        if (w_frame_last) r_frame_cnt <= '0;
        else r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/servo_motion_sequencer.sv
// rtl/servo_motion_sequencer.sv - three-channel servo slew sequencer with PWM generation
module servo_motion_sequencer
  import servo_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int FRAME_US      = 20000,
  parameter int PW_MIN_US     = 500,
  parameter int PW_MAX_US     = 2500,
  parameter int PW_RST_US     = 1500,
  parameter int STEP_US       = 20,
  parameter int SETTLE_FRAMES = 10
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_mask,
  input  logic [3*PW_W-1:0]    cmd_pw,
  output logic [3*PW_W-1:0]    cur_pw,
  output logic                 pwm1,
  output logic                 pwm2,
  output logic                 pwm3,
  output logic                 busy,
  output logic                 done
);

  localparam int TICK_DIV = CLK_HZ / 1_000_000;
  localparam int SET_W    = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

  state_t                 r_state;
  logic [2:0][PW_W-1:0]   r_cur;
  logic [2:0][PW_W-1:0]   r_tgt;
  logic [SET_W-1:0]       r_settle_cnt;
  logic                   r_done;
  logic [2:0]             r_pwm;

  logic [FRAME_W-1:0]     w_frame_cnt;
  logic                   w_us_tick;
  logic                   w_timer_frame_end;
  logic                   w_frame_end;
  logic [2:0][PW_W-1:0]   w_next;
  logic [2:0][PW_W-1:0]   w_cmd_pw;

  servo_frame_timer #(
    .TICK_DIV (TICK_DIV),
    .FRAME_US (FRAME_US)
  ) u_timer (
    .i_clk       (sysclk),
    .i_rst       (sysreset),
    .o_frame_cnt (w_frame_cnt),
    .o_us_tick   (w_us_tick),
    .o_frame_end (w_timer_frame_end)
  );

  // The timer's frame_end already implies a us tick; the FSM only ever advances on one
  assign w_frame_end = w_us_tick & w_timer_frame_end;
  assign w_cmd_pw    = cmd_pw;

  assign cur_pw    = r_cur;
  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign pwm1      = r_pwm[0];
  assign pwm2      = r_pwm[1];
  assign pwm3      = r_pwm[2];

  // Candidate pulse widths for the next frame, one bounded step toward each target
  always_comb begin
    w_next = r_cur;
    for (int n = 0; n < 3; n++) begin
      w_next[n] = step_toward(r_cur[n], r_tgt[n], PW_W'(STEP_US));
    end
  end

  // Command acceptance, per-frame slewing and settle countdown
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_state      <= IDLE;
      r_cur        <= {3{PW_W'(PW_RST_US)}};
      r_tgt        <= {3{PW_W'(PW_RST_US)}};
      r_settle_cnt <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            for (int n = 0; n < 3; n++) begin
              r_tgt[n] <= cmd_mask[n]
                ? clamp_pw(w_cmd_pw[n], PW_W'(PW_MIN_US), PW_W'(PW_MAX_US))
                : r_cur[n];
            end
            r_state <= RAMP;
          end
        end
        RAMP: begin
          if (w_frame_end) begin
            r_cur <= w_next;
            if (w_next == r_tgt) begin
              r_state      <= SETTLE;
              r_settle_cnt <= SET_W'(SETTLE_FRAMES);
            end
          end
        end
        SETTLE: begin
          if (w_frame_end) begin
            if (r_settle_cnt <= SET_W'(1)) begin
              r_settle_cnt <= '0;
              r_done       <= 1'b1;
              r_state      <= IDLE;
            end else begin
              r_settle_cnt <= r_settle_cnt - 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // PWM compare; cur_pw only moves at frame_end so each pulse is whole
  always_ff @(posedge sysclk) begin
    if (sysreset) begin
      r_pwm <= '0;
    end else begin
      for (int n = 0; n < 3; n++) begin
        r_pwm[n] <= (w_frame_cnt < {{(FRAME_W-PW_W){1'b0}}, r_cur[n]});
      end
    end
  end

endmodule
